// File: rtl/draw_mux_pkg.sv
// Shared types and helpers for the multi-channel draw-request multiplexer.
package draw_mux_pkg;

    typedef enum logic {
        PRIO_FIXED  = 1'b0,
        PRIO_ROTATE = 1'b1
    } prio_mode_t;

    localparam int MAX_CH = 16;

    // Index width for n channels, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-start priority picker: first asserted request at or after start_idx,
// wrapping modulo NUM_CH.
module rr_priority_picker
    import draw_mux_pkg::*;
#(
    parameter int  NUM_CH = 4,
    localparam int IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  start_idx,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    logic [NUM_CH-1:0] rot_req;
    logic [IDX_W-1:0]  off;
    logic [IDX_W:0]    sum;

    // Doubling the vector lets a plain right shift act as a rotation.
    assign rot_req = NUM_CH'({req, req} >> start_idx);

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                found = 1'b1;
                off   = IDX_W'(i);
            end
        end
        sum = {1'b0, start_idx} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(NUM_CH)) begin
            sum = sum - (IDX_W + 1)'(NUM_CH);
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/multi_draw_priority_mux.sv
// N-channel draw-request mux with fixed or per-frame rotating priority and registered outputs.
// Define MULTI_DRAW_OVERLAP_STATS_EN to build the per-frame overlap counter behind overlap_last.
module multi_draw_priority_mux
    import draw_mux_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  DATA_W = 8,
    parameter int  CNT_W  = 16,
    localparam int IDX_W  = idx_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        req_in,
    input  logic                     start_of_frame,
    input  logic                     rr_mode,
    output logic [DATA_W-1:0]        data_out,
    output logic                     drawRequestOut,
    output logic [IDX_W-1:0]         sel_idx,
    output logic                     overlap_now,
    output logic [CNT_W-1:0]         overlap_last
);

    if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("multi_draw_priority_mux: NUM_CH out of range");
    end

    prio_mode_t        mode;
    logic [IDX_W-1:0]  ptr_q, ptr_d, start_idx, pick_idx;
    logic              pick_found, overlap;
    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic              drq_q, drq_d, ovl_q, ovl_d;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_data[gi] = data_in[gi*DATA_W +: DATA_W];
    end

    assign mode      = prio_mode_t'(rr_mode);
    assign start_idx = (mode == PRIO_ROTATE) ? ptr_q : '0;
    assign overlap   = ($countones(req_in) >= 2);

    rr_priority_picker #(.NUM_CH(NUM_CH)) u_picker (
        .req       (req_in),
        .start_idx (start_idx),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    always_comb begin
        data_d = '0;
        sel_d  = '0;
        drq_d  = |req_in;
        ovl_d  = overlap;
        ptr_d  = ptr_q;
        if (pick_found) begin
            data_d = ch_data[pick_idx];
            sel_d  = pick_idx;
        end
        // The new pointer only takes effect from the cycle after start_of_frame.
        if (start_of_frame) begin
            if (mode == PRIO_ROTATE) begin
                ptr_d = (ptr_q == IDX_W'(NUM_CH - 1)) ? '0 : ptr_q + IDX_W'(1);
            end else begin
                ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            data_q <= '0;
            sel_q  <= '0;
            drq_q  <= 1'b0;
            ovl_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            data_q <= data_d;
            sel_q  <= sel_d;
            drq_q  <= drq_d;
            ovl_q  <= ovl_d;
        end
    end

    assign data_out       = data_q;
    assign sel_idx        = sel_q;
    assign drawRequestOut = drq_q;
    assign overlap_now    = ovl_q;

`ifdef MULTI_DRAW_OVERLAP_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next, last_q, last_d;

    always_comb begin
        cnt_next = cnt_q;
        if (overlap && (cnt_q != '1)) begin
            cnt_next = cnt_q + CNT_W'(1);
        end
        cnt_d  = cnt_next;
        last_d = last_q;
        // The frame total includes the start_of_frame cycle itself.
        if (start_of_frame) begin
            last_d = cnt_next;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign overlap_last = last_q;
`else
    assign overlap_last = '0;
`endif

endmodule

// File: tb/tb_multi_draw_priority_mux.sv
// Directed bench for multi_draw_priority_mux: a 4-channel instance driven from a vector table
// plus hand sequences, and a 3-channel instance for pointer wrap.
module tb_multi_draw_priority_mux;

`ifdef MULTI_DRAW_OVERLAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-channel instance with a narrow counter so saturation is reachable.
    logic [31:0] data_a;
    logic [3:0]  req_a;
    logic        sof_a, rr_a;
    logic [7:0]  dout_a;
    logic        drq_a, ovl_a;
    logic [1:0]  sel_a;
    logic [3:0]  last_a;

    // 3-channel instance for non-power-of-two pointer wrap.
    logic [23:0] data_b;
    logic [2:0]  req_b;
    logic        sof_b, rr_b;
    logic [7:0]  dout_b;
    logic        drq_b, ovl_b;
    logic [1:0]  sel_b;
    logic [3:0]  last_b;

    multi_draw_priority_mux #(.NUM_CH(4), .DATA_W(8), .CNT_W(4)) dut_a (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_a),
        .req_in         (req_a),
        .start_of_frame (sof_a),
        .rr_mode        (rr_a),
        .data_out       (dout_a),
        .drawRequestOut (drq_a),
        .sel_idx        (sel_a),
        .overlap_now    (ovl_a),
        .overlap_last   (last_a)
    );

    multi_draw_priority_mux #(.NUM_CH(3), .DATA_W(8), .CNT_W(4)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_b),
        .req_in         (req_b),
        .start_of_frame (sof_b),
        .rr_mode        (rr_b),
        .data_out       (dout_b),
        .drawRequestOut (drq_b),
        .sel_idx        (sel_b),
        .overlap_now    (ovl_b),
        .overlap_last   (last_b)
    );

    typedef struct {
        logic       rr;
        logic       sof;
        logic [3:0] req;
        logic [7:0] e_data;
        logic [1:0] e_sel;
        logic       e_drq;
        logic       e_ovl;
    } vec_t;

    vec_t vecs[17];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ch0=A0, ch1=11, ch2=22, ch3=33
        vecs[0]  = '{1'b0, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'b0110, 8'h11, 2'd1, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 4'b1000, 8'h33, 2'd3, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'b1111, 8'hA0, 2'd0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 4'b1001, 8'hA0, 2'd0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 4'b1001, 8'h33, 2'd3, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 4'b1001, 8'h33, 2'd3, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 4'b1001, 8'h33, 2'd3, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 4'b1001, 8'hA0, 2'd0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 4'b1111, 8'hA0, 2'd0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 4'b0011, 8'h11, 2'd1, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 4'b0011, 8'hA0, 2'd0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 4'b0110, 8'h11, 2'd1, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 4'b1111, 8'h22, 2'd2, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 4'b1111, 8'hA0, 2'd0, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 4'b1111, 8'hA0, 2'd0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0};

        reset  = 1'b1;
        data_a = {8'h33, 8'h22, 8'h11, 8'hA0};
        req_a  = '0;
        sof_a  = 1'b0;
        rr_a   = 1'b0;
        data_b = {8'h03, 8'h02, 8'h01};
        req_b  = '0;
        sof_b  = 1'b0;
        rr_b   = 1'b1;
        repeat (2) tick();
        chk("reset data_out", dout_a, 0);
        chk("reset sel_idx", sel_a, 0);
        chk("reset drawRequestOut", drq_a, 0);
        chk("reset overlap_now", ovl_a, 0);
        chk("reset overlap_last", last_a, 0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            rr_a  = vecs[i].rr;
            sof_a = vecs[i].sof;
            req_a = vecs[i].req;
            tick();
            chk($sformatf("v%0d data_out", i), dout_a, vecs[i].e_data);
            chk($sformatf("v%0d sel_idx", i), sel_a, vecs[i].e_sel);
            chk($sformatf("v%0d drawRequestOut", i), drq_a, vecs[i].e_drq);
            chk($sformatf("v%0d overlap_now", i), ovl_a, vecs[i].e_ovl);
        end

        // Mid-frame asynchronous reset with ptr advanced to 3.
        rr_a  = 1'b1;
        req_a = 4'b1111;
        sof_a = 1'b1;
        repeat (3) tick();
        sof_a = 1'b0;
        tick();
        chk("pre-reset sel_idx ptr3", sel_a, 3);
        reset = 1'b1;
        #1;
        chk("async reset data_out", dout_a, 0);
        chk("async reset sel_idx", sel_a, 0);
        chk("async reset drawRequestOut", drq_a, 0);
        chk("async reset overlap_now", ovl_a, 0);
        chk("async reset overlap_last", last_a, 0);
        tick();
        reset = 1'b0;
        req_a = 4'b0000;
        sof_a = 1'b1;
        tick();
        chk("post-reset sof overlap_last", last_a, 0);
        sof_a = 1'b0;
        req_a = 4'b1111;
        tick();
        chk("post-reset ptr restarted", sel_a, 1);

        // Counter saturation and restart.
        rr_a  = 1'b0;
        req_a = 4'b0000;
        sof_a = 1'b1;
        tick();
        sof_a = 1'b0;
        req_a = 4'b0011;
        repeat (20) tick();
        req_a = 4'b0001;
        sof_a = 1'b1;
        tick();
        chk("saturated overlap_last", last_a, STATS ? 15 : 0);
        chk("single req overlap_now", ovl_a, 0);
        sof_a = 1'b0;
        req_a = 4'b0011;
        repeat (3) tick();
        sof_a = 1'b1;
        tick();
        chk("restarted overlap_last", last_a, STATS ? 4 : 0);
        sof_a = 1'b0;
        req_a = 4'b0000;
        tick();
        chk("overlap_last held", last_a, STATS ? 4 : 0);

        // Three channels: ptr 0,1,2,0, one overlap cycle per frame.
        req_b = 3'b111;
        sof_b = 1'b1;
        for (int f = 0; f < 4; f++) begin
            tick();
            chk($sformatf("nch3 f%0d sel_idx", f), sel_b, f % 3);
            chk($sformatf("nch3 f%0d data_out", f), dout_b, (f % 3) + 1);
            chk($sformatf("nch3 f%0d overlap_last", f), last_b, STATS ? 1 : 0);
        end
        sof_b = 1'b0;
        req_b = 3'b101;
        tick();
        chk("nch3 ptr1 wrap pick", sel_b, 2);
        chk("nch3 ptr1 wrap drq", drq_b, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_draw_priority_mux.md
Name: multi_draw_priority_mux

Overview:
- Parametrised N-channel draw-request multiplexer for the VGA object layer (fruits, vines, enemies).
- Selects one requesting channel's DATA_W-bit payload per pixel clock and registers it with 1-cycle latency.
- Supports fixed or per-frame rotating priority, so overlapping objects of equal rank flicker fairly rather than always hiding the same one.
- Counts multi-request (overlap) pixels per frame for collision and debug logic; sits between the object generators and the layer/colour mux.

Parameters:
- NUM_CH, 4, number of request channels (2..16).
- DATA_W, 8, payload width per channel.
- CNT_W, 16, overlap counter width (used only with OVERLAP_STATS_EN).
- Derived: IDX_W = max(1, $clog2(NUM_CH)).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous reset, active-high.
- data_in  in  NUM_CH*DATA_W  channel payloads; channel k occupies bits [k*DATA_W +: DATA_W].
- req_in  in  NUM_CH  per-channel draw request.
- start_of_frame  in  1  single-cycle pulse at the first pixel of a frame.
- rr_mode  in  1  0 = fixed priority (channel 0 highest), 1 = rotating priority.
- data_out  out  DATA_W  registered selected payload.
- drawRequestOut  out  1  registered OR of req_in.
- sel_idx  out  IDX_W  registered index of the winning channel.
- overlap_now  out  1  registered; high when 2 or more requests were active.
- overlap_last  out  CNT_W  overlap-pixel count of the previous frame (OVERLAP_STATS_EN only).

Behaviour:
- Reset (async, reset=1):
  - data_out, drawRequestOut, sel_idx, overlap_now, overlap_last cleared to 0.
  - Internal pointer ptr and overlap count cleared to 0.
  - Reset asserted mid-frame drops all state immediately. The count restarts at 0; overlap_last reads 0 until the next start_of_frame.
- Latency: all outputs are registered 1 cycle after their inputs; there is no combinational path to any output.
- Selection, fixed mode (rr_mode=0): the lowest-index asserted req_in wins.
- Selection, rotating mode (rr_mode=1): scan starts at channel ptr and proceeds ptr, ptr+1, …, wrapping modulo NUM_CH; the first asserted channel wins.
- No request: data_out = 0, sel_idx = 0, drawRequestOut = 0.
- Pointer update (evaluated on start_of_frame only):
  - rr_mode=1: ptr <= (ptr == NUM_CH-1) ? 0 : ptr+1.
  - rr_mode=0: ptr <= 0.
- start_of_frame in the same cycle as requests: selection uses the old ptr; the new ptr applies from the next cycle.
- rr_mode change mid-frame: takes effect for selection on the next cycle; ptr is not altered until start_of_frame.
- overlap_now <= (popcount(req_in) >= 2).
- Overlap count:
  - cnt_next = cnt + overlap, saturating at 2^CNT_W-1, with no wrap.
  - On start_of_frame: overlap_last <= cnt_next (includes the current cycle), then cnt <= 0.
  - Otherwise cnt <= cnt_next.
- NUM_CH not a power of 2: ptr never exceeds NUM_CH-1, and channels at or above NUM_CH do not exist.

Optional Feature:
- Macro: MULTI_DRAW_OVERLAP_STATS_EN.
- Defined: the overlap counter and overlap_last are present as above.
- Undefined: the counter logic is removed, and overlap_last is tied to 0. overlap_now remains in both builds.

Decomposition:
- Package draw_mux_pkg holds:
  - typedef prio_mode_t enum {PRIO_FIXED=1'b0, PRIO_ROTATE=1'b1};
  - the IDX_W helper function;
  - localparam MAX_CH = 16.
- Sub-module rr_priority_picker (params NUM_CH):
  - Combinational: inputs req and start index; outputs found and idx.
  - Implemented as a double-width request vector with a priority encode and a modulo fold.
- The top level owns the pointer, the output registers and the counter.

Test Plan:
- Reset at mid-frame with req_in=4'b1111: all outputs 0 within the same cycle. After release, a start_of_frame gives overlap_last=0.
- Fixed mode, req_in=4'b0110, data ch1=0x11, ch2=0x22: next cycle data_out=0x11, sel_idx=1, drawRequestOut=1, overlap_now=1.
- Rotating mode, req_in=4'b1001 held, one start_of_frame per frame:
  - ptr sequence 0,1,2,3,0.
  - Winners per frame: ch0, ch3, ch3, ch3, ch0.
- Rotating mode, start_of_frame coincident with req_in=4'b0011 and ptr=1: that cycle selects ch1; the following cycle, with the same req, selects ch0 (ptr=2 wraps).
- Overlap stats, CNT_W=4: 20 overlap cycles, then start_of_frame on a non-overlap cycle gives overlap_last=15 (saturated), and the next frame's count restarts from 0.
- NUM_CH=3, rotating mode, 4 frames: ptr sequence 0,1,2,0. Repeat with the macro undefined: overlap_last stays 0 throughout.
